// File: rtl/ptp_rtc_adj_ctrl.sv
// rtl/ptp_rtc_adj_ctrl.sv - PTP RTC offset/clear/tick adjustment arbiter
module ptp_rtc_adj_ctrl #(
    parameter int unsigned HOLDOFF   = 8,
    parameter logic [31:0] TICK_INIT = 32'h1999_9999
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst,
    input  logic        sw_req_i,
    input  logic [31:0] sw_ns_offset_i,
    input  logic [47:0] sw_sc_offset_i,
    output logic        sw_ack_o,
    output logic        sw_err_o,
    input  logic        srv_req_i,
    input  logic [31:0] srv_ns_offset_i,
    input  logic [47:0] srv_sc_offset_i,
    output logic        srv_ack_o,
    output logic        srv_err_o,
    input  logic        sw_clear_i,
    input  logic        tick_wr_i,
    input  logic [31:0] tick_wdata_i,
    output logic [31:0] tick_inc_o,
    output logic [31:0] ns_offset_o,
    output logic [47:0] sc_offset_o,
    output logic        offset_valid_o,
    output logic        clear_rtc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    localparam logic [7:0]         HOLD_LOAD = 8'(HOLDOFF);
    localparam logic signed [31:0] NS_LIMIT  = 32'sd1000000000;

    state_t      state, state_next;
    logic [7:0]  hold_cnt, hold_cnt_next;
    logic        last_srv, last_srv_next;   // 1: servo was granted last
    logic        gnt_srv, gnt_srv_next;     // requester owning the current grant
    logic        any_req, strobes_quiet, pick_srv, sel_ns_ok;
    logic [31:0] sel_ns;
    logic [47:0] sel_sc;
    logic        load_offsets, issue, reject;

    // Arbitration, range check and next-state selection; clear overrides everything
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        last_srv_next = last_srv;
        gnt_srv_next  = gnt_srv;
        load_offsets  = 1'b0;
        issue         = 1'b0;
        reject        = 1'b0;

        any_req       = sw_req_i | srv_req_i;
        // A req still high in the cycle of our own ack/err is a stale one
        strobes_quiet = ~(sw_ack_o | sw_err_o | srv_ack_o | srv_err_o);
        pick_srv      = srv_req_i & (~sw_req_i | ~last_srv);
        sel_ns        = pick_srv ? srv_ns_offset_i : sw_ns_offset_i;
        sel_sc        = pick_srv ? srv_sc_offset_i : sw_sc_offset_i;
        sel_ns_ok     = ($signed(sel_ns) < NS_LIMIT) && ($signed(sel_ns) > -NS_LIMIT);

        if (sw_clear_i) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && strobes_quiet) begin
                        last_srv_next = pick_srv;
                        gnt_srv_next  = pick_srv;
                        if (sel_ns_ok) begin
                            load_offsets = 1'b1;
                            state_next   = ISSUE;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    issue         = 1'b1;
                    state_next    = HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
                HOLD: begin
                    if (hold_cnt <= 8'd1) begin
                        state_next    = IDLE;
                        hold_cnt_next = 8'd0;
                    end else begin
                        hold_cnt_next = hold_cnt - 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, pointer, offset, tick and strobe registers
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            state          <= IDLE;
            hold_cnt       <= 8'd0;
            last_srv       <= 1'b1;
            gnt_srv        <= 1'b0;
            tick_inc_o     <= TICK_INIT;
            ns_offset_o    <= 32'd0;
            sc_offset_o    <= 48'd0;
            offset_valid_o <= 1'b0;
            clear_rtc_o    <= 1'b0;
            sw_ack_o       <= 1'b0;
            sw_err_o       <= 1'b0;
            srv_ack_o      <= 1'b0;
            srv_err_o      <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_next;
            hold_cnt       <= hold_cnt_next;
            last_srv       <= last_srv_next;
            gnt_srv        <= gnt_srv_next;
            offset_valid_o <= issue;
            sw_ack_o       <= issue & ~gnt_srv;
            srv_ack_o      <= issue & gnt_srv;
            sw_err_o       <= reject & ~gnt_srv_next;
            srv_err_o      <= reject & gnt_srv_next;
            clear_rtc_o    <= sw_clear_i;
            // Busy also spans the settle cycle after HOLD, before a new grant can land
            busy_o         <= (state != IDLE) || (state_next != IDLE);
            if (load_offsets) begin
                ns_offset_o <= sel_ns;
                sc_offset_o <= sel_sc;
            end
            if (tick_wr_i && (tick_wdata_i != 32'd0)) begin
                tick_inc_o <= tick_wdata_i;
            end
        end
    end

endmodule
